// File: rtl/cdm_dot_acc.sv
// Saturating accumulator over a run of LEN unsigned products from the approximate multiplier.
// Result is presented on a valid/ready port and held until the sink accepts it.
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the last run's values
// ACC   | accepting products, one per clock when p_valid is high
// OUT   | result valid, waiting for res_ready
module cdm_dot_acc #(
    parameter int PW    = 16,
    parameter int AW    = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic [PW-1:0]    p_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [AW-1:0]    res_data,
    output logic             res_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;

    logic             xfer;
    logic [AW:0]      sum;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        xfer    = (state_q == ACC) && p_valid;
        // one spare bit catches the carry out of the AW-bit sum
        sum     = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, p_data};

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        len_d   = len;
                        state_d = ACC;
                    end else begin
                        state_d = OUT;
                    end
                end
            end
            ACC: begin
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (sum[AW]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum[AW-1:0];
                    end
                    if (cnt_q == len_q - 1'b1) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    // acc/ovf are only rewritten in ACC or on start, so they double as the held result
    assign p_ready   = (state_q == ACC);
    assign res_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign res_data  = acc_q;
    assign res_ovf   = ovf_q;

endmodule

// File: tb/tb_cdm_dot_acc.sv
// Directed bench for cdm_dot_acc, built with AW=17 so saturation is reachable in a short run.
// Inputs change and outputs are sampled on the falling edge.
module tb_cdm_dot_acc;

    localparam int PW    = 16;
    localparam int AW    = 17;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             p_valid;
    logic             p_ready;
    logic [PW-1:0]    p_data;
    logic             res_valid;
    logic             res_ready;
    logic [AW-1:0]    res_data;
    logic             res_ovf;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    cdm_dot_acc #(.PW(PW), .AW(AW), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .p_data    (p_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; len = '0; p_valid = 1'b0; p_data = '0; res_ready = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        vectors++; if (p_ready !== 1'b0) begin miscompares++; $display("FAIL reset_p_ready got %0b exp 0", p_ready); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got %0b exp 0", res_valid); end
        vectors++; if (res_data !== 17'h0) begin miscompares++; $display("FAIL reset_res_data got %h exp 0", res_data); end
        vectors++; if (res_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_res_ovf got %0b exp 0", res_ovf); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b exp 0", busy); end
    endtask

    task automatic test_basic;
        start = 1'b1; len = 8'd3;
        cyc(1);
        start = 1'b0;
        vectors++; if (busy !== 1'b1 || p_ready !== 1'b1) begin miscompares++; $display("FAIL basic_acc_entry got busy=%0b p_ready=%0b exp 1 1", busy, p_ready); end
        p_valid = 1'b1; p_data = 16'd100; cyc(1);
        p_data = 16'd200; cyc(1);
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid got %0b exp 0", res_valid); end
        p_data = 16'd300; cyc(1);
        p_valid = 1'b0;
        vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL basic_res_valid got %0b exp 1", res_valid); end
        vectors++; if (res_data !== 17'd600) begin miscompares++; $display("FAIL basic_res_data got %0d exp 600", res_data); end
        vectors++; if (res_ovf !== 1'b0) begin miscompares++; $display("FAIL basic_res_ovf got %0b exp 0", res_ovf); end
        vectors++; if (p_ready !== 1'b0) begin miscompares++; $display("FAIL basic_out_p_ready got %0b exp 0", p_ready); end
        res_ready = 1'b1; cyc(1); res_ready = 1'b0;
        vectors++; if (res_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle got res_valid=%0b busy=%0b exp 0 0", res_valid, busy); end
        vectors++; if (res_data !== 17'd600) begin miscompares++; $display("FAIL basic_idle_hold got %0d exp 600", res_data); end
    endtask

    task automatic test_gaps_backpressure;
        start = 1'b1; len = 8'd2; cyc(1); start = 1'b0;
        p_valid = 1'b1; p_data = 16'hFFFF; cyc(1);
        p_valid = 1'b0; p_data = 16'h1234; cyc(3);
        vectors++; if (busy !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("FAIL gap_hold got busy=%0b res_valid=%0b exp 1 0", busy, res_valid); end
        p_valid = 1'b1; p_data = 16'd1; cyc(1); p_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (res_valid !== 1'b1 || res_data !== 17'h10000) begin miscompares++; $display("FAIL bp_hold[%0d] got valid=%0b data=%h exp 1 10000", i, res_valid, res_data); end
            cyc(1);
        end
        res_ready = 1'b1;
        vectors++; if (res_valid !== 1'b1 || res_data !== 17'h10000) begin miscompares++; $display("FAIL bp_handshake got valid=%0b data=%h exp 1 10000", res_valid, res_data); end
        cyc(1); res_ready = 1'b0;
        vectors++; if (res_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL bp_idle got valid=%0b busy=%0b exp 0 0", res_valid, busy); end
        cyc(1);
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL bp_single_hs got %0b exp 0", res_valid); end
    endtask

    task automatic test_saturation;
        start = 1'b1; len = 8'd3; cyc(1); start = 1'b0;
        p_valid = 1'b1; p_data = 16'hFFFF; cyc(3); p_valid = 1'b0;
        vectors++; if (res_data !== 17'h1FFFF) begin miscompares++; $display("FAIL sat_data got %h exp 1ffff", res_data); end
        vectors++; if (res_ovf !== 1'b1 || res_valid !== 1'b1) begin miscompares++; $display("FAIL sat_ovf got ovf=%0b valid=%0b exp 1 1", res_ovf, res_valid); end
        res_ready = 1'b1; cyc(1); res_ready = 1'b0;
        start = 1'b1; len = 8'd1; cyc(1); start = 1'b0;
        p_valid = 1'b1; p_data = 16'd5; cyc(1); p_valid = 1'b0;
        vectors++; if (res_data !== 17'd5 || res_ovf !== 1'b0) begin miscompares++; $display("FAIL sat_next_run got data=%0d ovf=%0b exp 5 0", res_data, res_ovf); end
        res_ready = 1'b1; cyc(1); res_ready = 1'b0;
    endtask

    task automatic test_empty_run;
        start = 1'b1; len = 8'd0; p_valid = 1'b1; p_data = 16'd77; cyc(1); start = 1'b0;
        vectors++; if (res_valid !== 1'b1 || p_ready !== 1'b0) begin miscompares++; $display("FAIL empty_out got valid=%0b p_ready=%0b exp 1 0", res_valid, p_ready); end
        vectors++; if (res_data !== 17'd0 || res_ovf !== 1'b0) begin miscompares++; $display("FAIL empty_data got data=%0d ovf=%0b exp 0 0", res_data, res_ovf); end
        p_valid = 1'b0;
        res_ready = 1'b1; cyc(1); res_ready = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL empty_idle got busy=%0b exp 0", busy); end
    endtask

    task automatic test_ignored_start;
        start = 1'b1; len = 8'd2; cyc(1); start = 1'b0;
        p_valid = 1'b1; p_data = 16'd7; cyc(1);
        start = 1'b1; len = 8'd9; p_data = 16'd8; cyc(1);
        start = 1'b0; p_valid = 1'b0;
        vectors++; if (res_valid !== 1'b1 || res_data !== 17'd15) begin miscompares++; $display("FAIL ign_result got valid=%0b data=%0d exp 1 15", res_valid, res_data); end
        res_ready = 1'b1; cyc(1); res_ready = 1'b0;
        cyc(1);
        vectors++; if (busy !== 1'b0 || p_ready !== 1'b0) begin miscompares++; $display("FAIL ign_no_rerun got busy=%0b p_ready=%0b exp 0 0", busy, p_ready); end
    endtask

    task automatic test_reset_mid_run;
        start = 1'b1; len = 8'd4; cyc(1); start = 1'b0;
        p_valid = 1'b1; p_data = 16'd10; cyc(1);
        p_data = 16'd20; cyc(1); p_valid = 1'b0;
        rst = 1'b1; cyc(1); rst = 1'b0;
        vectors++; if (busy !== 1'b0 || p_ready !== 1'b0 || res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ctrl got busy=%0b p_ready=%0b valid=%0b exp 0 0 0", busy, p_ready, res_valid); end
        vectors++; if (res_data !== 17'd0 || res_ovf !== 1'b0) begin miscompares++; $display("FAIL rst_mid_data got data=%0d ovf=%0b exp 0 0", res_data, res_ovf); end
        start = 1'b1; len = 8'd1; cyc(1); start = 1'b0;
        p_valid = 1'b1; p_data = 16'd42; cyc(1); p_valid = 1'b0;
        vectors++; if (res_valid !== 1'b1 || res_data !== 17'd42) begin miscompares++; $display("FAIL rst_next_run got valid=%0b data=%0d exp 1 42", res_valid, res_data); end
        res_ready = 1'b1; cyc(1); res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps_backpressure();
        test_saturation();
        test_empty_run();
        test_ignored_start();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
